uart_rx_fifo: RTL and testbench

Parametrised next-generation UART receiver.
- 16x oversampling with 3-sample majority voting at mid-bit.
- 16550-style line control: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
- Per-word parity, framing and break status.
- Received words are buffered in a first-word-fall-through receive FIFO with a ready/valid read port.
- Sits between the pad-side serial line and the host/control logic, in place of the single-register receiver path.

---
 rtl/uart_rx_fifo.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 16x-oversampled UART receiver (5-8 data bits, parity, 1/2 stop)
//            feeding a first-word-fall-through receive FIFO.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_FREQ    = 1843200,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_rx,
    input  logic                          rst,
    input  logic [1:0]                    baud_sel,
    input  logic                          serial_data_tx,
    input  logic [4:0]                    line_control_reg,
    input  logic                          rx_ready,
    input  logic                          overrun_clr,
    output logic [7:0]                    data_received,
    output logic                          rx_valid,
    output logic                          parity_error,
    output logic                          framing_error,
    output logic                          break_detected,
    output logic                          overrun_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          active_flag_rx,
    output logic                          transmission_done_flag
);

    function automatic int calc_div(input int baud);
        int d;
        d = (CLK_FREQ + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

    localparam int c_DIV_9600   = calc_div(9600);
    localparam int c_DIV_19200  = calc_div(19200);
    localparam int c_DIV_57600  = calc_div(57600);
    localparam int c_DIV_115200 = calc_div(115200);
    localparam int DW = (c_DIV_9600 > 1) ? $clog2(c_DIV_9600) : 1;
    localparam logic [DW-1:0] c_DM1_9600   = DW'(c_DIV_9600 - 1);
    localparam logic [DW-1:0] c_DM1_19200  = DW'(c_DIV_19200 - 1);
    localparam logic [DW-1:0] c_DM1_57600  = DW'(c_DIV_57600 - 1);
    localparam logic [DW-1:0] c_DM1_115200 = DW'(c_DIV_115200 - 1);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] c_IDX_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] c_IDX_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   c_FULL     = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] c_IDX_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] c_IDX_S2   = TW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP1     = 3'd4,
        S_STOP2     = 3'd5,
        S_WAIT_IDLE = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DW-1:0]  r_div_cnt;
    logic [DW-1:0]  w_div_m1;
    logic [1:0]     r_baud_lat;
    logic [1:0]     w_baud_eff;
    logic           w_tick;
    logic [SYNC_STAGES-1:0] r_sync;
    logic           w_line;
    logic [TW-1:0]  r_tick_cnt;
    logic [TW-1:0]  w_idx;
    logic           w_in_frame;
    logic           w_mid;
    logic           w_bnd;
    logic           r_s0;
    logic           r_s1;
    logic           w_maj;
    logic [4:0]     r_lcr;
    logic [7:0]     r_data;
    logic [2:0]     r_bit_cnt;
    logic           r_pe;
    logic           r_fe;
    logic           r_brk;
    logic           w_last_bit;
    logic           w_par_exp;
    logic           w_fe_fin;
    logic           w_bi_fin;
    logic           w_start;
    logic           w_finish;
    logic [10:0]    w_word;

    // Divisor follows baud_sel only while idle; a frame keeps the rate it started with.
    always_comb begin
        w_baud_eff = (r_state == S_IDLE) ? baud_sel : r_baud_lat;
        case (w_baud_eff)
            2'b00:   w_div_m1 = c_DM1_9600;
            2'b01:   w_div_m1 = c_DM1_19200;
            2'b10:   w_div_m1 = c_DM1_57600;
            default: w_div_m1 = c_DM1_115200;
        endcase
    end

    assign w_tick = (r_div_cnt >= w_div_m1);

    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk_rx or posedge rst) begin
                if (rst) r_sync <= '1;
                else     r_sync <= serial_data_tx;
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk_rx or posedge rst) begin
                if (rst) r_sync <= '1;
                else     r_sync <= {r_sync[SYNC_STAGES-2:0], serial_data_tx};
            end
        end
    endgenerate

    assign w_line = r_sync[SYNC_STAGES-1];

    // r_tick_cnt holds the index of the last tick seen in the current bit.
    assign w_idx      = (r_tick_cnt == c_IDX_LAST) ? '0 : r_tick_cnt + TW'(1);
    assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_PARITY)
                     || (r_state == S_STOP1) || (r_state == S_STOP2);
    assign w_mid      = w_tick && w_in_frame && (w_idx == c_IDX_S2);
    assign w_bnd      = w_tick && w_in_frame && (w_idx == '0);
    assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_line) | (r_s1 & w_line);
    assign w_last_bit = (r_bit_cnt == ({1'b0, r_lcr[1:0]} + 3'd4));
    assign w_par_exp  = (^r_data) ^ ~r_lcr[4];
    assign w_fe_fin   = r_fe | ~w_maj;
    assign w_bi_fin   = r_brk & ~w_maj;
    assign w_word     = {w_bi_fin, w_fe_fin, r_pe, r_data};

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && !w_line) begin
                    w_state_nxt = S_START;
                    w_start     = 1'b1;
                end
            end
            S_START: begin
                if (w_mid && w_maj)  w_state_nxt = S_IDLE;
                else if (w_bnd)      w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bnd && w_last_bit) w_state_nxt = r_lcr[3] ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                if (w_bnd) w_state_nxt = S_STOP1;
            end
            S_STOP1: begin
                if (w_mid && !r_lcr[2])     w_finish    = 1'b1;
                else if (w_bnd && r_lcr[2]) w_state_nxt = S_STOP2;
            end
            S_STOP2: begin
                if (w_mid) w_finish = 1'b1;
            end
            S_WAIT_IDLE: begin
                if (w_tick && w_line) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A frame ends at the mid-bit decision of its last stop bit.
        if (w_finish) w_state_nxt = w_fe_fin ? S_WAIT_IDLE : S_IDLE;
    end

    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_baud_lat <= '0;
            r_lcr      <= '0;
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_pe       <= 1'b0;
            r_fe       <= 1'b0;
            r_brk      <= 1'b0;
        end else if (w_start) begin
            r_tick_cnt <= '0;
            r_baud_lat <= baud_sel;
            r_lcr      <= line_control_reg;
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_pe       <= 1'b0;
            r_fe       <= 1'b0;
            r_brk      <= 1'b1;
        end else if (w_tick && w_in_frame) begin
            r_tick_cnt <= w_idx;
            if (w_idx == c_IDX_S0) r_s0 <= w_line;
            if (w_idx == c_IDX_S1) r_s1 <= w_line;
            if (w_mid) begin
                if (w_maj) r_brk <= 1'b0;
                case (r_state)
                    S_DATA:   r_data[r_bit_cnt] <= w_maj;
                    S_PARITY: r_pe <= w_maj ^ w_par_exp;
                    S_STOP1:  if (!w_maj) r_fe <= 1'b1;
                    default:  ;
                endcase
            end
            if (w_bnd && (r_state == S_DATA)) r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    logic [10:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovr;
    logic          r_done;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;
    logic [10:0]   w_head;

    assign w_full    = (r_count == c_FULL);
    assign w_pop     = rx_valid && rx_ready;
    assign w_push_ok = w_finish && (!w_full || w_pop);

    always_ff @(posedge clk_rx) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // Setting has priority over a coincident clear.
            if (w_finish && !w_push_ok) r_ovr <= 1'b1;
            else if (overrun_clr)       r_ovr <= 1'b0;
        end
    end

    assign w_head                 = r_mem[r_rd_ptr];
    assign rx_valid               = (r_count != '0);
    assign data_received          = rx_valid ? w_head[7:0] : 8'h00;
    assign parity_error           = rx_valid & w_head[8];
    assign framing_error          = rx_valid & w_head[9];
    assign break_detected         = rx_valid & w_head[10];
    assign overrun_flag           = r_ovr;
    assign fifo_count             = r_count;
    assign active_flag_rx         = (r_state != S_IDLE);
    assign transmission_done_flag = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo with a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk_rx = 1'b0;
    logic       rst;
    logic [1:0] baud_sel;
    logic       serial_data_tx;
    logic [4:0] line_control_reg;
    logic       rx_ready;
    logic       overrun_clr;
    logic [7:0] data_received;
    logic       rx_valid;
    logic       parity_error;
    logic       framing_error;
    logic       break_detected;
    logic       overrun_flag;
    logic [4:0] fifo_count;
    logic       active_flag_rx;
    logic       transmission_done_flag;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [10:0] exp_q[$];

    uart_rx_fifo #(
        .CLK_FREQ(1843200), .OVERSAMPLE(16), .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) dut (
        .clk_rx(clk_rx), .rst(rst), .baud_sel(baud_sel), .serial_data_tx(serial_data_tx),
        .line_control_reg(line_control_reg), .rx_ready(rx_ready), .overrun_clr(overrun_clr),
        .data_received(data_received), .rx_valid(rx_valid), .parity_error(parity_error),
        .framing_error(framing_error), .break_detected(break_detected),
        .overrun_flag(overrun_flag), .fifo_count(fifo_count), .active_flag_rx(active_flag_rx),
        .transmission_done_flag(transmission_done_flag)
    );

    always #5 clk_rx = ~clk_rx;

    always @(negedge clk_rx) if (transmission_done_flag) done_cnt++;

    function automatic int div_of(input logic [1:0] bs);
        int baud;
        int d;
        case (bs)
            2'b00:   baud = 9600;
            2'b01:   baud = 19200;
            2'b10:   baud = 57600;
            default: baud = 115200;
        endcase
        d = (1843200 + baud * 8) / (baud * 16);
        return (d < 1) ? 1 : d;
    endfunction

    // Expected head entry {break, framing, parity, data} for one frame.
    function automatic logic [10:0] model_word(input logic [7:0] d, input logic [4:0] lcr,
                                               input logic pbit, input logic [1:0] stops);
        int n;
        logic [7:0] dm;
        logic even_xor, exp_p, pe, fe, bi, two;
        n = 5 + int'(lcr[1:0]);
        dm = 8'h00;
        for (int i = 0; i < 8; i++) if (i < n) dm[i] = d[i];
        even_xor = ^dm;
        exp_p = lcr[4] ? even_xor : ~even_xor;
        two = lcr[2];
        pe = lcr[3] && (pbit != exp_p);
        fe = !stops[0] || (two && !stops[1]);
        bi = (dm == 8'h00) && (!lcr[3] || !pbit) && !stops[0] && (!two || !stops[1]);
        return {bi, fe, pe, dm};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [4:0] lcr, input logic [1:0] bs,
                              input logic pbit, input logic [1:0] stops, input int gap);
        int bt;
        int n;
        bt = 16 * div_of(bs);
        n = 5 + int'(lcr[1:0]);
        @(negedge clk_rx);
        baud_sel = bs;
        line_control_reg = lcr;
        serial_data_tx = 1'b0;
        repeat (bt) @(negedge clk_rx);
        for (int i = 0; i < n; i++) begin
            serial_data_tx = d[i];
            repeat (bt) @(negedge clk_rx);
        end
        if (lcr[3]) begin
            serial_data_tx = pbit;
            repeat (bt) @(negedge clk_rx);
        end
        serial_data_tx = stops[0];
        repeat (bt) @(negedge clk_rx);
        if (lcr[2]) begin
            serial_data_tx = stops[1];
            repeat (bt) @(negedge clk_rx);
        end
        serial_data_tx = 1'b1;
        repeat (gap * bt) @(negedge clk_rx);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_rx);
        total++;
        if ({data_received, rx_valid, parity_error, framing_error, break_detected,
             overrun_flag, fifo_count, active_flag_rx, transmission_done_flag} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {data_received, rx_valid, parity_error,
                     framing_error, break_detected, overrun_flag, fifo_count, active_flag_rx,
                     transmission_done_flag});
        end
        rst = 1'b0;
        repeat (20) @(negedge clk_rx);
        total++;
        if (active_flag_rx !== 1'b0 || done_cnt !== 0) begin
            bad++;
            $display("FAIL reset_idle active=%b done=%0d want 0/0", active_flag_rx, done_cnt);
        end
    endtask

    task automatic test_basic();
        int d0;
        logic [10:0] e;
        d0 = done_cnt;
        e = model_word(8'hA5, 5'b00011, 1'b0, 2'b11);
        send_frame(8'hA5, 5'b00011, 2'b11, 1'b0, 2'b11, 2);
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++; $display("FAIL basic_done got=%0d want=1", done_cnt - d0);
        end
        total++;
        if (rx_valid !== 1'b1 || fifo_count !== 5'd1) begin
            bad++; $display("FAIL basic_valid got=%b/%0d want=1/1", rx_valid, fifo_count);
        end
        total++;
        if ({break_detected, framing_error, parity_error, data_received} !== e) begin
            bad++; $display("FAIL basic_word got=%h want=%h",
                            {break_detected, framing_error, parity_error, data_received}, e);
        end
        rx_ready = 1'b1;
        @(negedge clk_rx);
        rx_ready = 1'b0;
        total++;
        if (rx_valid !== 1'b0 || fifo_count !== 5'd0) begin
            bad++; $display("FAIL basic_pop got=%b/%0d want=0/0", rx_valid, fifo_count);
        end
    endtask

    task automatic test_parity();
        logic [10:0] e;
        for (int p = 0; p < 2; p++) begin
            e = model_word(8'h35, 5'b11110, 1'(p), 2'b11);
            send_frame(8'h35, 5'b11110, 2'b00, 1'(p), 2'b11, 2);
            total++;
            if (fifo_count !== 5'd1 ||
                {break_detected, framing_error, parity_error, data_received} !== e) begin
                bad++; $display("FAIL parity_7e2 pbit=%0d got=%h cnt=%0d want=%h cnt=1", p,
                                {break_detected, framing_error, parity_error, data_received},
                                fifo_count, e);
            end
            rx_ready = 1'b1;
            @(negedge clk_rx);
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_false_start();
        int d0;
        d0 = done_cnt;
        baud_sel = 2'b11;
        @(negedge clk_rx);
        serial_data_tx = 1'b0;
        repeat (4) @(negedge clk_rx);
        total++;
        if (active_flag_rx !== 1'b1) begin
            bad++; $display("FAIL false_start_active got=%b want=1", active_flag_rx);
        end
        serial_data_tx = 1'b1;
        repeat (40) @(negedge clk_rx);
        total++;
        if (active_flag_rx !== 1'b0 || done_cnt - d0 !== 0 || fifo_count !== 5'd0) begin
            bad++; $display("FAIL false_start_idle active=%b done=%0d cnt=%0d want 0/0/0",
                            active_flag_rx, done_cnt - d0, fifo_count);
        end
    endtask

    task automatic test_framing_break();
        int d0;
        logic [10:0] e;
        d0 = done_cnt;
        exp_q.delete();
        exp_q.push_back(model_word(8'h3C, 5'b00011, 1'b0, 2'b00));
        send_frame(8'h3C, 5'b00011, 2'b11, 1'b0, 2'b00, 2);
        exp_q.push_back(model_word(8'h00, 5'b00011, 1'b0, 2'b00));
        serial_data_tx = 1'b0;
        repeat (20 * 16) @(negedge clk_rx);
        total++;
        if (active_flag_rx !== 1'b1 || done_cnt - d0 !== 2 || fifo_count !== 5'd2) begin
            bad++; $display("FAIL break_hold active=%b done=%0d cnt=%0d want 1/2/2",
                            active_flag_rx, done_cnt - d0, fifo_count);
        end
        serial_data_tx = 1'b1;
        repeat (32) @(negedge clk_rx);
        total++;
        if (active_flag_rx !== 1'b0 || done_cnt - d0 !== 2) begin
            bad++; $display("FAIL break_release active=%b done=%0d want 0/2",
                            active_flag_rx, done_cnt - d0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rx_valid !== 1'b1 ||
                {break_detected, framing_error, parity_error, data_received} !== e) begin
                bad++; $display("FAIL break_word got=%h valid=%b want=%h",
                                {break_detected, framing_error, parity_error, data_received},
                                rx_valid, e);
            end
            rx_ready = 1'b1;
            @(negedge clk_rx);
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_overrun();
        int d0;
        logic model_ovr;
        logic [10:0] e;
        d0 = done_cnt;
        model_ovr = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            e = model_word(8'(i), 5'b00011, 1'b0, 2'b11);
            if (exp_q.size() < 16) exp_q.push_back(e);
            else model_ovr = 1'b1;
            send_frame(8'(i), 5'b00011, 2'b11, 1'b0, 2'b11, 1);
        end
        total++;
        if (done_cnt - d0 !== 17 || fifo_count !== 5'(exp_q.size()) || overrun_flag !== model_ovr) begin
            bad++; $display("FAIL overrun_fill done=%0d cnt=%0d ovr=%b want 17/%0d/%b",
                            done_cnt - d0, fifo_count, overrun_flag, exp_q.size(), model_ovr);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rx_valid !== 1'b1 ||
                {break_detected, framing_error, parity_error, data_received} !== e) begin
                bad++; $display("FAIL overrun_drain got=%h valid=%b want=%h",
                                {break_detected, framing_error, parity_error, data_received},
                                rx_valid, e);
            end
            rx_ready = 1'b1;
            @(negedge clk_rx);
            rx_ready = 1'b0;
        end
        total++;
        if (rx_valid !== 1'b0 || fifo_count !== 5'd0 || overrun_flag !== 1'b1) begin
            bad++; $display("FAIL overrun_empty valid=%b cnt=%0d ovr=%b want 0/0/1",
                            rx_valid, fifo_count, overrun_flag);
        end
        overrun_clr = 1'b1;
        @(negedge clk_rx);
        overrun_clr = 1'b0;
        total++;
        if (overrun_flag !== 1'b0) begin
            bad++; $display("FAIL overrun_clear got=%b want=0", overrun_flag);
        end
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [4:0]  lcr;
        logic [1:0]  bs;
        logic        pb;
        logic [1:0]  st;
        logic [10:0] e;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            d   = 8'($urandom);
            lcr = 5'($urandom_range(0, 31));
            bs  = 2'($urandom_range(0, 3));
            pb  = 1'($urandom);
            st  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 5) == 0) begin
                d = 8'h00; pb = 1'b0; st = 2'b00;
            end
            exp_q.push_back(model_word(d, lcr, pb, st));
            send_frame(d, lcr, bs, pb, st, 2);
        end
        total++;
        if (fifo_count !== 5'(exp_q.size()) || overrun_flag !== 1'b0) begin
            bad++; $display("FAIL random_count cnt=%0d ovr=%b want %0d/0",
                            fifo_count, overrun_flag, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rx_valid !== 1'b1 ||
                {break_detected, framing_error, parity_error, data_received} !== e) begin
                bad++; $display("FAIL random_word got=%h valid=%b want=%h",
                                {break_detected, framing_error, parity_error, data_received},
                                rx_valid, e);
            end
            rx_ready = 1'b1;
            @(negedge clk_rx);
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        logic [7:0] v;
        send_frame(8'h77, 5'b00011, 2'b11, 1'b0, 2'b11, 1);
        v = 8'h5A;
        @(negedge clk_rx);
        serial_data_tx = 1'b0;
        repeat (16) @(negedge clk_rx);
        for (int i = 0; i < 3; i++) begin
            serial_data_tx = v[i];
            repeat (16) @(negedge clk_rx);
        end
        serial_data_tx = v[3];
        repeat (8) @(negedge clk_rx);
        total++;
        if (active_flag_rx !== 1'b1 || fifo_count !== 5'd1) begin
            bad++; $display("FAIL midreset_pre active=%b cnt=%0d want 1/1",
                            active_flag_rx, fifo_count);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({data_received, rx_valid, parity_error, framing_error, break_detected,
             overrun_flag, fifo_count, active_flag_rx, transmission_done_flag} !== 21'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h want=0", {data_received, rx_valid,
                     parity_error, framing_error, break_detected, overrun_flag, fifo_count,
                     active_flag_rx, transmission_done_flag});
        end
        @(negedge clk_rx);
        serial_data_tx = 1'b1;
        repeat (3) @(negedge clk_rx);
        rst = 1'b0;
        repeat (32) @(negedge clk_rx);
        d0 = done_cnt;
        send_frame(v, 5'b00011, 2'b11, 1'b0, 2'b11, 2);
        total++;
        if (done_cnt - d0 !== 1 || fifo_count !== 5'd1 || data_received !== v ||
            {break_detected, framing_error, parity_error} !== 3'b000) begin
            bad++; $display("FAIL midreset_after done=%0d cnt=%0d data=%h flags=%b want 1/1/%h/000",
                            done_cnt - d0, fifo_count, data_received,
                            {break_detected, framing_error, parity_error}, v);
        end
        rx_ready = 1'b1;
        @(negedge clk_rx);
        rx_ready = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        serial_data_tx   = 1'b1;
        baud_sel         = 2'b11;
        line_control_reg = 5'b00011;
        rx_ready         = 1'b0;
        overrun_clr      = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_framing_break();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
